// File: rtl/vscale_hasti_sram_slave_pkg.sv
// Shared HASTI bus constants, slave state encoding and request capture type.
package vscale_hasti_sram_slave_pkg;

    localparam int HASTI_ADDR_WIDTH  = 32;
    localparam int HASTI_BUS_WIDTH   = 32;
    localparam int HASTI_SIZE_WIDTH  = 3;
    localparam int HASTI_BURST_WIDTH = 3;
    localparam int HASTI_PROT_WIDTH  = 4;
    localparam int HASTI_TRANS_WIDTH = 2;
    localparam int HASTI_RESP_WIDTH  = 1;
    localparam int HASTI_NUM_LANES   = HASTI_BUS_WIDTH / 8;

    localparam logic [HASTI_TRANS_WIDTH-1:0] HASTI_TRANS_IDLE   = 2'd0;
    localparam logic [HASTI_TRANS_WIDTH-1:0] HASTI_TRANS_BUSY   = 2'd1;
    localparam logic [HASTI_TRANS_WIDTH-1:0] HASTI_TRANS_NONSEQ = 2'd2;
    localparam logic [HASTI_TRANS_WIDTH-1:0] HASTI_TRANS_SEQ    = 2'd3;

    localparam logic [HASTI_RESP_WIDTH-1:0] HASTI_RESP_OKAY  = 1'b0;
    localparam logic [HASTI_RESP_WIDTH-1:0] HASTI_RESP_ERROR = 1'b1;

    localparam logic [HASTI_SIZE_WIDTH-1:0] HASTI_SIZE_BYTE = 3'd0;
    localparam logic [HASTI_SIZE_WIDTH-1:0] HASTI_SIZE_HALF = 3'd1;
    localparam logic [HASTI_SIZE_WIDTH-1:0] HASTI_SIZE_WORD = 3'd2;

    typedef enum logic [1:0] {
        SLV_IDLE = 2'd0,
        SLV_DATA = 2'd1,
        SLV_ERR1 = 2'd2,
        SLV_ERR2 = 2'd3
    } slv_state_t;

    // Transfer attributes captured at address accept, held through the data phase.
    typedef struct packed {
        logic [HASTI_ADDR_WIDTH-1:0] offset;   // haddr - BASE_ADDR
        logic                        write;
        logic [HASTI_NUM_LANES-1:0]  strobe;
    } hasti_req_t;

    // NONSEQ and SEQ both start a transfer; IDLE and BUSY do not.
    function automatic logic trans_active(input logic [HASTI_TRANS_WIDTH-1:0] trans);
        return (trans == HASTI_TRANS_NONSEQ) || (trans == HASTI_TRANS_SEQ);
    endfunction

endpackage

// File: rtl/vscale_hasti_byte_lanes.sv
// Maps transfer size and low address bits to byte-lane strobes and an
// alignment-legal flag. Purely combinational; shared by HASTI slaves.
module vscale_hasti_byte_lanes
    import vscale_hasti_sram_slave_pkg::*;
(
    input  logic [HASTI_SIZE_WIDTH-1:0] size,
    input  logic [1:0]                  addr_lo,
    output logic [HASTI_NUM_LANES-1:0]  strobe,
    output logic                        legal
);

    // Decode size into lanes; sizes above a word and misaligned halves/words are illegal.
    always_comb begin
        strobe = '0;
        legal  = 1'b0;
        case (size)
            HASTI_SIZE_BYTE: begin
                strobe = 4'b0001 << addr_lo;
                legal  = 1'b1;
            end
            HASTI_SIZE_HALF: begin
                strobe = 4'b0011 << addr_lo;
                legal  = ~addr_lo[0];
            end
            HASTI_SIZE_WORD: begin
                strobe = 4'b1111;
                legal  = (addr_lo == 2'b00);
            end
            default: begin
                strobe = '0;
                legal  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/vscale_hasti_sram_slave.sv
// HASTI single-port SRAM responder: address/data phase pipeline, optional
// wait states per OKAY data phase, and the two-cycle ERROR response.
module vscale_hasti_sram_slave
    import vscale_hasti_sram_slave_pkg::*;
#(
    parameter int          NWORDS      = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int          WAIT_STATES = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [HASTI_ADDR_WIDTH-1:0]  haddr,
    input  logic                         hwrite,
    input  logic [HASTI_SIZE_WIDTH-1:0]  hsize,
    input  logic [HASTI_BURST_WIDTH-1:0] hburst,
    input  logic                         hmastlock,
    input  logic [HASTI_PROT_WIDTH-1:0]  hprot,
    input  logic [HASTI_TRANS_WIDTH-1:0] htrans,
    input  logic [HASTI_BUS_WIDTH-1:0]   hwdata,
    output logic [HASTI_BUS_WIDTH-1:0]   hrdata,
    output logic                         hready,
    output logic [HASTI_RESP_WIDTH-1:0]  hresp
);

    localparam int          IDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [32:0] SPAN  = 33'(NWORDS) * 33'd4;
    localparam logic [2:0]  WS    = 3'(WAIT_STATES);

    slv_state_t                 state;
    logic [2:0]                 wait_cnt;
    hasti_req_t                 req;

    logic [HASTI_NUM_LANES-1:0] lane_strobe;
    logic                       lane_legal;
    logic [31:0]                offset;
    logic                       in_range;
    logic                       accept;
    logic                       complete;
    logic [IDX_W-1:0]           idx;

    logic [HASTI_BUS_WIDTH-1:0] mem [NWORDS];

    vscale_hasti_byte_lanes u_lanes (
        .size    (hsize),
        .addr_lo (haddr[1:0]),
        .strobe  (lane_strobe),
        .legal   (lane_legal)
    );

    // Addresses below BASE_ADDR wrap to large offsets, so one compare covers both ends.
    assign offset   = haddr - BASE_ADDR;
    assign in_range = ({1'b0, offset} < SPAN);
    assign accept   = hready && trans_active(htrans);
    assign complete = (state == SLV_DATA) && (wait_cnt == 3'd0);
    assign idx      = req.offset[IDX_W+1:2];

    // Transfer FSM with registered hready/hresp.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= SLV_IDLE;
            wait_cnt <= 3'd0;
            hready   <= 1'b1;
            hresp    <= HASTI_RESP_OKAY;
            req      <= '0;
        end else if (state == SLV_ERR1) begin
            state  <= SLV_ERR2;
            hready <= 1'b1;
            hresp  <= HASTI_RESP_ERROR;
        end else if (state == SLV_DATA && wait_cnt != 3'd0) begin
            wait_cnt <= wait_cnt - 3'd1;
            hready   <= (wait_cnt == 3'd1);
            hresp    <= HASTI_RESP_OKAY;
        end else if (accept) begin
            // IDLE, ERR2 and the DATA completion cycle all accept the next address.
            req.offset <= offset;
            req.write  <= hwrite;
            req.strobe <= lane_strobe;
            if (lane_legal && in_range) begin
                state    <= SLV_DATA;
                wait_cnt <= WS;
                hready   <= (WS == 3'd0);
                hresp    <= HASTI_RESP_OKAY;
            end else begin
                state    <= SLV_ERR1;
                wait_cnt <= 3'd0;
                hready   <= 1'b0;
                hresp    <= HASTI_RESP_ERROR;
            end
        end else begin
            state    <= SLV_IDLE;
            wait_cnt <= 3'd0;
            hready   <= 1'b1;
            hresp    <= HASTI_RESP_OKAY;
        end
    end

    // Commit write bytes at the end of the completion cycle; reset discards it.
    always_ff @(posedge clk) begin
        if (!reset && complete && req.write) begin
            for (int i = 0; i < HASTI_NUM_LANES; i++) begin
                if (req.strobe[i])
                    mem[idx][8*i +: 8] <= hwdata[8*i +: 8];
            end
        end
    end

    // Read data only on a read completion cycle. Because writes land at the
    // end of their completion cycle, a read immediately behind sees them.
    assign hrdata = (complete && !req.write) ? mem[idx] : '0;

    logic unused_inputs;
    assign unused_inputs = ^{hburst, hmastlock, hprot, req.offset};

endmodule

// File: tb/tb_vscale_hasti_sram_slave.sv
// Directed bench for vscale_hasti_sram_slave: three instances (0/2/3 wait
// states) share one bus; only the selected one sees active htrans.
module tb_vscale_hasti_sram_slave;

    localparam int NW = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] haddr = '0;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = 3'd2;
    logic [1:0]  htrans = 2'd0;
    logic [31:0] hwdata = '0;
    int          sel = 0;

    logic [1:0]  htrans_v [3];
    logic [31:0] hrdata_v [3];
    logic        hready_v [3];
    logic [0:0]  hresp_v  [3];

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 3; i++) htrans_v[i] = (sel == i) ? htrans : 2'd0;
    end

    vscale_hasti_sram_slave #(.NWORDS(NW), .BASE_ADDR(32'h0), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset), .haddr(haddr), .hwrite(hwrite), .hsize(hsize),
        .hburst(3'd0), .hmastlock(1'b0), .hprot(4'd0), .htrans(htrans_v[0]),
        .hwdata(hwdata), .hrdata(hrdata_v[0]), .hready(hready_v[0]), .hresp(hresp_v[0]));
    vscale_hasti_sram_slave #(.NWORDS(NW), .BASE_ADDR(32'h0), .WAIT_STATES(2)) dut1 (
        .clk(clk), .reset(reset), .haddr(haddr), .hwrite(hwrite), .hsize(hsize),
        .hburst(3'd0), .hmastlock(1'b0), .hprot(4'd0), .htrans(htrans_v[1]),
        .hwdata(hwdata), .hrdata(hrdata_v[1]), .hready(hready_v[1]), .hresp(hresp_v[1]));
    vscale_hasti_sram_slave #(.NWORDS(NW), .BASE_ADDR(32'h0), .WAIT_STATES(3)) dut2 (
        .clk(clk), .reset(reset), .haddr(haddr), .hwrite(hwrite), .hsize(hsize),
        .hburst(3'd0), .hmastlock(1'b0), .hprot(4'd0), .htrans(htrans_v[2]),
        .hwdata(hwdata), .hrdata(hrdata_v[2]), .hready(hready_v[2]), .hresp(hresp_v[2]));

    logic        hready_s;
    logic [0:0]  hresp_s;
    logic [31:0] hrdata_s;
    assign hready_s = hready_v[sel];
    assign hresp_s  = hresp_v[sel];
    assign hrdata_s = hrdata_v[sel];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // ---------------- Behavioural model ----------------
    // The response is a queue of expected per-cycle bus states. Each accepted
    // transfer appends its whole response; an empty queue means idle.
    typedef struct packed {
        bit       rdy;
        bit       rsp;
        bit       done;
        bit       wr;
        int       key;
        bit [3:0] strb;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mm [int];
    bit          run_cmp = 1'b0;

    function automatic int ws_of(input int s);
        return (s == 0) ? 0 : (s == 1) ? 2 : 3;
    endfunction

    function automatic exp_t idle_e();
        exp_t e;
        e = '0;
        e.rdy = 1'b1;
        return e;
    endfunction

    function automatic int key_of(input int s, input logic [31:0] a);
        return s * 4096 + int'((a >> 2) % NW);
    endfunction

    always @(posedge clk) begin
        exp_t        cur;
        exp_t        e;
        bit          acc;
        bit          ok;
        logic [31:0] w;
        if (reset) begin
            q.delete();
        end else begin
            cur = (q.size() > 0) ? q[0] : idle_e();
            if (cur.done && cur.wr) begin
                w = mm.exists(cur.key) ? mm[cur.key] : 32'h0;
                for (int b = 0; b < 4; b++)
                    if (cur.strb[b]) w[8*b +: 8] = hwdata[8*b +: 8];
                mm[cur.key] = w;
            end
            acc = cur.rdy && (htrans == 2'd2 || htrans == 2'd3);
            if (q.size() > 0) void'(q.pop_front());
            if (acc) begin
                ok = 1'b1;
                if (hsize > 3'd2) ok = 1'b0;
                if (hsize == 3'd1 && haddr[0]) ok = 1'b0;
                if (hsize == 3'd2 && haddr[1:0] != 2'b00) ok = 1'b0;
                if (haddr >= 32'(4 * NW)) ok = 1'b0;
                if (!ok) begin
                    e = '0; e.rsp = 1'b1;                 q.push_back(e);
                    e = '0; e.rsp = 1'b1; e.rdy = 1'b1;   q.push_back(e);
                end else begin
                    for (int k = 0; k < ws_of(sel); k++) begin
                        e = '0; q.push_back(e);
                    end
                    e = '0;
                    e.rdy  = 1'b1;
                    e.done = 1'b1;
                    e.wr   = hwrite;
                    e.key  = key_of(sel, haddr);
                    e.strb = (hsize == 3'd0) ? (4'b0001 << haddr[1:0]) :
                             (hsize == 3'd1) ? (4'b0011 << haddr[1:0]) : 4'b1111;
                    q.push_back(e);
                end
            end
        end
    end

    // Compare selected DUT against the model on every cycle.
    always @(negedge clk) begin
        exp_t e;
        if (run_cmp) begin
            e = (q.size() > 0) ? q[0] : idle_e();
            chk("cyc_hready", {31'b0, hready_s}, {31'b0, e.rdy});
            chk("cyc_hresp",  {31'b0, hresp_s},  {31'b0, e.rsp});
            if (e.done && !e.wr) begin
                if (mm.exists(e.key)) chk("cyc_hrdata", hrdata_s, mm[e.key]);
            end else begin
                chk("cyc_hrdata_zero", hrdata_s, 32'h0);
            end
        end
    end

    // ---------------- Stimulus helpers ----------------
    // Drive an address phase, hold it until accepted, then present hwdata for its data phase.
    task automatic issue(input logic [31:0] a, input logic w, input logic [2:0] s, input logic [31:0] d);
        int n;
        haddr = a; hwrite = w; hsize = s; htrans = 2'd2;
        n = 0;
        @(negedge clk);
        while (!hready_s && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("issue_timeout", 32'(n), 32'd0);
        @(posedge clk); #1;
        htrans = 2'd0;
        hwdata = d;
    endtask

    // Count stall cycles of the current data phase and capture the completion bus state.
    task automatic wait_done(output int stalls, output logic [31:0] d, output logic rsp);
        stalls = 0;
        @(negedge clk);
        while (!hready_s && stalls < 50) begin
            stalls++;
            @(negedge clk);
        end
        if (stalls >= 50) chk("done_timeout", 32'(stalls), 32'd0);
        d   = hrdata_s;
        rsp = hresp_s[0];
    endtask

    task automatic expect_read(input string nm, input logic [31:0] a, input logic [31:0] exp);
        int          st;
        logic [31:0] d;
        logic        r;
        issue(a, 1'b0, 3'd2, 32'h0);
        wait_done(st, d, r);
        chk(nm, d, exp);
        @(posedge clk); #1;
    endtask

    task automatic chk_err(input string nm);
        @(negedge clk);
        chk({nm, "_e1_rdy"}, {31'b0, hready_s}, 32'd0);
        chk({nm, "_e1_rsp"}, {31'b0, hresp_s},  32'd1);
        @(negedge clk);
        chk({nm, "_e2_rdy"}, {31'b0, hready_s}, 32'd1);
        chk({nm, "_e2_rsp"}, {31'b0, hresp_s},  32'd1);
        @(posedge clk); #1;
    endtask

    task automatic settle(input int n);
        htrans = 2'd0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int          st;
        logic [31:0] d;
        logic        r;

        // Reset state of all instances
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("rst_hready", {31'b0, hready_v[i]}, 32'd1);
            chk("rst_hresp",  {31'b0, hresp_v[i]},  32'd0);
            chk("rst_hrdata", hrdata_v[i], 32'h0);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        run_cmp = 1'b1;

        // ---- zero wait states ----
        sel = 0;
        issue(32'h10, 1'b1, 3'd2, 32'hDEADBEEF);
        issue(32'h10, 1'b0, 3'd2, 32'h0);
        wait_done(st, d, r);
        chk("b2b_stalls", 32'(st), 32'd0);
        chk("b2b_data", d, 32'hDEADBEEF);
        @(posedge clk); #1;

        issue(32'h20, 1'b1, 3'd2, 32'h11223344);
        issue(32'h21, 1'b1, 3'd0, 32'h0000AA00);
        issue(32'h22, 1'b1, 3'd0, 32'h00550000);
        expect_read("byte_merge", 32'h20, 32'h1155AA44);
        chk("mdl_byte_merge", mm[key_of(0, 32'h20)], 32'h1155AA44);

        issue(32'h30, 1'b1, 3'd2, 32'hCAFEF00D);
        issue(32'h03, 1'b0, 3'd1, 32'h0);
        chk_err("half_misalign");
        issue(32'h32, 1'b1, 3'd2, 32'hFFFFFFFF);
        chk_err("word_misalign_wr");
        expect_read("misalign_no_write", 32'h30, 32'hCAFEF00D);

        issue(32'(4 * NW), 1'b0, 3'd2, 32'h0);
        chk_err("out_of_range");
        issue(32'h0, 1'b0, 3'd3, 32'h0);
        chk_err("bad_size");

        for (int i = 0; i < 6; i++) begin
            haddr = 32'h30 + 32'(i); hwrite = i[0]; hsize = 3'(i % 3);
            htrans = (i % 2 == 0) ? 2'd0 : 2'd1;
            @(negedge clk);
            chk("idlebusy_rdy", {31'b0, hready_s}, 32'd1);
            chk("idlebusy_rsp", {31'b0, hresp_s},  32'd0);
            @(posedge clk); #1;
        end
        htrans = 2'd0;
        expect_read("idlebusy_no_write", 32'h30, 32'hCAFEF00D);

        // ---- two wait states ----
        settle(2);
        sel = 1;
        issue(32'h08, 1'b1, 3'd2, 32'h0BADF00D);
        issue(32'h08, 1'b0, 3'd2, 32'h0);
        haddr = 32'h08; hwrite = 1'b0; hsize = 3'd2; htrans = 2'd2;
        wait_done(st, d, r);
        chk("ws2_stalls", 32'(st), 32'd2);
        chk("ws2_resp", {31'b0, r}, 32'd0);
        chk("ws2_data", d, 32'h0BADF00D);
        @(posedge clk); #1;
        htrans = 2'd0;
        wait_done(st, d, r);
        chk("ws2_held_stalls", 32'(st), 32'd2);
        chk("ws2_held_data", d, 32'h0BADF00D);
        @(posedge clk); #1;
        wait_done(st, d, r);
        chk("ws2_no_reaccept", 32'(st), 32'd0);
        @(posedge clk); #1;

        // ---- three wait states, reset mid write ----
        settle(2);
        sel = 2;
        issue(32'h40, 1'b1, 3'd2, 32'hA5A5A5A5);
        settle(6);
        issue(32'h40, 1'b1, 3'd2, 32'h12345678);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid_rdy", {31'b0, hready_s}, 32'd1);
        chk("rst_mid_rsp", {31'b0, hresp_s},  32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        expect_read("rst_no_commit", 32'h40, 32'hA5A5A5A5);

        settle(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
